// File: rtl/mem_io_sequencer.sv
// Memory-port sequencer: owns the single data-RAM port and hands it between the
// processor (RUN) and a paced valid/ready streaming engine (STREAM). The processor
// is held in reset outside RUN. Two MMIO input registers are decoded on the
// processor read path.
module mem_io_sequencer #(
  parameter int unsigned       ADDR_W      = 18,
  parameter int unsigned       DATA_W      = 8,
  parameter logic [ADDR_W-1:0] MMIO_BASE   = 18'h3D08D,
  parameter int unsigned       STREAM_BASE = 0,
  parameter int unsigned       STREAM_LEN  = 76800,
  parameter int unsigned       PACE_DIV    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cpu_done,
  output logic              cpu_rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wren,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [DATA_W-1:0] mmio_in0,
  input  logic [DATA_W-1:0] mmio_in1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state
);

  // Beat index must be able to hold STREAM_LEN itself (the "all fetched" value).
  localparam int unsigned IdxW  = $clog2(STREAM_LEN + 1);
  localparam int unsigned PaceW = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;

  localparam logic [IdxW-1:0]   LenIdx     = IdxW'(STREAM_LEN);
  localparam logic [IdxW-1:0]   LastIdx    = IdxW'(STREAM_LEN - 1);
  localparam logic [PaceW-1:0]  PaceReload = PaceW'(PACE_DIV - 1);
  localparam logic [ADDR_W-1:0] BaseAddr   = ADDR_W'(STREAM_BASE);
  localparam logic [ADDR_W-1:0] Mmio1Addr  = MMIO_BASE + ADDR_W'(1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StStream = 2'd2,
    StDone   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [IdxW-1:0]  fetch_idx_q, fetch_idx_d;
  logic [PaceW-1:0] pace_q, pace_d;

  // Two-entry output FIFO: circular storage with separate read/write pointers.
  logic [1:0][DATA_W-1:0] fifo_data_q, fifo_data_d;
  logic [1:0]             fifo_last_q, fifo_last_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic [1:0]             count_q, count_d;

  logic              stream_enter;
  logic              pop;
  logic              fetch;
  logic              head_last;
  logic [ADDR_W-1:0] stream_addr;

  assign out_valid   = (count_q != 2'd0);
  assign out_data    = fifo_data_q[rd_ptr_q];
  assign head_last   = fifo_last_q[rd_ptr_q];
  assign out_last    = out_valid & head_last;
  assign pop         = out_valid & out_ready;
  assign stream_addr = BaseAddr + ADDR_W'(fetch_idx_q);
  assign state       = state_q;

  // A fetch needs a free slot once this cycle's pop (if any) has been taken into account.
  assign fetch = (state_q == StStream) && (fetch_idx_q < LenIdx) && (pace_q == '0) &&
                 ((count_q != 2'd2) || pop);

  // Processor read path: MMIO decode in front of RAM read data.
  always_comb begin
    cpu_rdata = mem_rdata;
    if (cpu_addr == MMIO_BASE) begin
      cpu_rdata = mmio_in0;
    end else if (cpu_addr == Mmio1Addr) begin
      cpu_rdata = mmio_in1;
    end
  end

  // Sequencer FSM next state and RAM-port / processor-control outputs.
  always_comb begin
    state_d      = state_q;
    stream_enter = 1'b0;
    cpu_rst      = 1'b1;
    mem_wren     = 1'b0;
    mem_addr     = BaseAddr;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        cpu_rst  = 1'b0;
        mem_addr = cpu_addr;
        mem_wren = cpu_wren;
        busy     = 1'b1;
        if (cpu_done) begin
          state_d      = StStream;
          stream_enter = 1'b1;
        end
      end
      StStream: begin
        mem_addr = stream_addr;
        busy     = 1'b1;
        if (pop && head_last) state_d = StDone;
      end
      StDone: begin
        done = 1'b1;
        if (start) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
    // Abort overrides every other transition.
    if (abort) begin
      state_d      = StIdle;
      stream_enter = 1'b0;
    end
  end

  // Stream engine next state: beat index, pacing counter and FIFO.
  always_comb begin
    fetch_idx_d = fetch_idx_q;
    pace_d      = pace_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    if (abort || stream_enter) begin
      fetch_idx_d = '0;
      pace_d      = '0;
      rd_ptr_d    = 1'b0;
      wr_ptr_d    = 1'b0;
      count_d     = 2'd0;
    end else begin
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (fetch) begin
        fifo_data_d[wr_ptr_q] = mem_rdata;
        fifo_last_d[wr_ptr_q] = (fetch_idx_q == LastIdx);
        wr_ptr_d              = ~wr_ptr_q;
        fetch_idx_d           = fetch_idx_q + IdxW'(1);
        pace_d                = PaceReload;
      end else if (pace_q != '0) begin
        pace_d = pace_q - PaceW'(1);
      end
      count_d = count_q + 2'(fetch) - 2'(pop);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      fetch_idx_q <= '0;
      pace_q      <= '0;
      fifo_data_q <= '0;
      fifo_last_q <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      fetch_idx_q <= fetch_idx_d;
      pace_q      <= pace_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule
